// File: rtl/leaderboard_pkg.sv
// Shared constants and helpers for the stopwatch leaderboard.
package leaderboard_pkg;

  localparam logic [1:0] MODE_FAST = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;

  localparam logic [2:0] DISP_LIVE  = 3'b000;
  localparam logic [2:0] DISP_RANK1 = 3'b100;
  localparam logic [2:0] DISP_RANK2 = 3'b101;
  localparam logic [2:0] DISP_RANK3 = 3'b110;

  localparam int unsigned NUM_RANKS = 3;
  localparam int unsigned RANK_W    = 2;

  // Rank 1..3 to one-hot (bit0 = rank 1); rank 0 means not placed.
  function automatic logic [NUM_RANKS-1:0] rank_onehot(input logic [RANK_W-1:0] rank);
    logic [NUM_RANKS-1:0] oh;
    oh = '0;
    case (rank)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b011 + 3'b001;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/leaderboard_rank_table.sv
// Three-entry sorted best-times table; ASCENDING=1 keeps smallest first, 0 keeps largest first.
module leaderboard_rank_table
  import leaderboard_pkg::*;
#(
  parameter int unsigned W         = 6,
  parameter bit          ASCENDING = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insert,
  input  logic [W-1:0]         value,
  output logic [RANK_W-1:0]    rank_c,
  output logic [W-1:0]         entry_1,
  output logic [W-1:0]         entry_2,
  output logic [W-1:0]         entry_3,
  output logic [NUM_RANKS-1:0] valid
);

  logic [NUM_RANKS-1:0][W-1:0] entry_q;
  logic [NUM_RANKS-1:0][W-1:0] entry_d;
  logic [NUM_RANKS-1:0]        valid_q;
  logic [NUM_RANKS-1:0]        valid_d;
  logic [NUM_RANKS-1:0]        beats_c;
  logic [RANK_W-1:0]           kept_c;

  // Entries are sorted, so the ones the new value fails to beat form a prefix of length kept_c.
  always_comb begin
    beats_c = '0;
    kept_c  = '0;
    for (int i = 0; i < int'(NUM_RANKS); i++) begin
      if (ASCENDING) beats_c[i] = !valid_q[i] || (value < entry_q[i]);
      else           beats_c[i] = !valid_q[i] || (value > entry_q[i]);
      if (!beats_c[i]) kept_c = kept_c + 2'd1;
    end
    rank_c = (kept_c == 2'd3) ? 2'd0 : kept_c + 2'd1;
  end

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    case (kept_c)
      2'd0: begin
        entry_d = {entry_q[1], entry_q[0], value};
        valid_d = {valid_q[1], valid_q[0], 1'b1};
      end
      2'd1: begin
        entry_d = {entry_q[1], value, entry_q[0]};
        valid_d = {valid_q[1], 1'b1, valid_q[0]};
      end
      2'd2: begin
        entry_d = {value, entry_q[1], entry_q[0]};
        valid_d = {1'b1, valid_q[1], valid_q[0]};
      end
      default: begin
        entry_d = entry_q;
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      valid_q <= '0;
    end else if (insert && (rank_c != 2'd0)) begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry_1 = entry_q[0];
  assign entry_2 = entry_q[1];
  assign entry_3 = entry_q[2];
  assign valid   = valid_q;

endmodule

// File: rtl/leaderboard.sv
// Fast/slow top-3 leaderboards with rank sound strobes, rank LEDs and display select.
// Optional: define LEADERBOARD_SOUND_STRETCH_EN to hold each sound output for SOUND_CYCLES cycles.
module leaderboard
  import leaderboard_pkg::*;
#(
  parameter int unsigned TIME_W       = 6,
  parameter int unsigned SOUND_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic [1:0]        stopwatch_mode,
  input  logic [2:0]        display_mode,
  output logic              signal_sound_1,
  output logic              signal_sound_2,
  output logic              signal_sound_3,
  output logic [2:0]        leaderboard_LED,
  output logic [1:0]        slow_or_fast,
  output logic [TIME_W-1:0] time_out
);

  logic [TIME_W-1:0]    prev_time;
  logic [NUM_RANKS-1:0] sound_q;
  logic                 active_c;
  logic                 submit_c;
  logic                 is_fast_c;
  logic [RANK_W-1:0]    fast_rank_c;
  logic [RANK_W-1:0]    slow_rank_c;
  logic [NUM_RANKS-1:0] onehot_c;
  logic [TIME_W-1:0]    fast_e1, fast_e2, fast_e3;
  logic [TIME_W-1:0]    slow_e1, slow_e2, slow_e3;
  logic [NUM_RANKS-1:0] fast_valid, slow_valid;
  logic [TIME_W-1:0]    disp_c;

  assign is_fast_c = (stopwatch_mode == MODE_FAST);
  assign active_c  = is_fast_c || (stopwatch_mode == MODE_SLOW);
  assign submit_c  = active_c && (time_in != prev_time) && (time_in != '0);
  assign onehot_c  = rank_onehot(is_fast_c ? fast_rank_c : slow_rank_c);

  leaderboard_rank_table #(.W(TIME_W), .ASCENDING(1'b1)) u_fast (
    .clk     (clk),
    .rst     (rst),
    .insert  (submit_c && is_fast_c),
    .value   (time_in),
    .rank_c  (fast_rank_c),
    .entry_1 (fast_e1),
    .entry_2 (fast_e2),
    .entry_3 (fast_e3),
    .valid   (fast_valid)
  );

  leaderboard_rank_table #(.W(TIME_W), .ASCENDING(1'b0)) u_slow (
    .clk     (clk),
    .rst     (rst),
    .insert  (submit_c && !is_fast_c),
    .value   (time_in),
    .rank_c  (slow_rank_c),
    .entry_1 (slow_e1),
    .entry_2 (slow_e2),
    .entry_3 (slow_e3),
    .valid   (slow_valid)
  );

  // Display source: live time or a stored rank of the board currently shown.
  always_comb begin
    disp_c = '0;
    case (display_mode)
      DISP_RANK1: disp_c = (slow_or_fast == MODE_SLOW) ? (slow_valid[0] ? slow_e1 : '0)
                                                       : (fast_valid[0] ? fast_e1 : '0);
      DISP_RANK2: disp_c = (slow_or_fast == MODE_SLOW) ? (slow_valid[1] ? slow_e2 : '0)
                                                       : (fast_valid[1] ? fast_e2 : '0);
      DISP_RANK3: disp_c = (slow_or_fast == MODE_SLOW) ? (slow_valid[2] ? slow_e3 : '0)
                                                       : (fast_valid[2] ? fast_e3 : '0);
      default:    disp_c = display_mode[2] ? '0 : time_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_time       <= '0;
      leaderboard_LED <= '0;
      slow_or_fast    <= MODE_FAST;
      time_out        <= '0;
    end else begin
      prev_time <= time_in;
      time_out  <= disp_c;
      if (submit_c) leaderboard_LED <= onehot_c;
      if (active_c) slow_or_fast    <= stopwatch_mode;
    end
  end

`ifdef LEADERBOARD_SOUND_STRETCH_EN
  localparam int unsigned CNT_W = $clog2(SOUND_CYCLES + 1);
  logic [CNT_W-1:0] stretch_cnt;

  // A new submission restarts the stretch and moves the pulse to the new rank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sound_q     <= '0;
      stretch_cnt <= '0;
    end else if (submit_c) begin
      sound_q     <= onehot_c;
      stretch_cnt <= (onehot_c != '0) ? CNT_W'(SOUND_CYCLES - 1) : '0;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - CNT_W'(1);
    end else begin
      sound_q <= '0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sound_q <= '0;
    else     sound_q <= submit_c ? onehot_c : '0;
  end
`endif

  assign signal_sound_1 = sound_q[0];
  assign signal_sound_2 = sound_q[1];
  assign signal_sound_3 = sound_q[2];

endmodule

// File: tb/tb_leaderboard.sv
// Directed bench for leaderboard (default build: single-cycle sound strobes).
module tb_leaderboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] time_in;
  logic [1:0] stopwatch_mode;
  logic [2:0] display_mode;
  logic       signal_sound_1, signal_sound_2, signal_sound_3;
  logic [2:0] leaderboard_LED;
  logic [1:0] slow_or_fast;
  logic [5:0] time_out;

  int errors = 0;
  int checks = 0;

  leaderboard #(.TIME_W(6), .SOUND_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .time_in         (time_in),
    .stopwatch_mode  (stopwatch_mode),
    .display_mode    (display_mode),
    .signal_sound_1  (signal_sound_1),
    .signal_sound_2  (signal_sound_2),
    .signal_sound_3  (signal_sound_3),
    .leaderboard_LED (leaderboard_LED),
    .slow_or_fast    (slow_or_fast),
    .time_out        (time_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] snd();
    return {29'd0, signal_sound_3, signal_sound_2, signal_sound_1};
  endfunction

  initial begin
    rst = 1'b1; time_in = '0; stopwatch_mode = 2'b00; display_mode = 3'b000;
    tick();
    check("reset_sound", snd(), 0);
    check("reset_led", 32'(leaderboard_LED), 0);
    check("reset_sof", 32'(slow_or_fast), 32'd1);
    check("reset_tout", 32'(time_out), 0);
    rst = 1'b0;

    // Fast mode: first entry
    stopwatch_mode = 2'b01; time_in = 6'd5; tick();
    check("f5_sound", snd(), 32'd1);
    check("f5_led", 32'(leaderboard_LED), 32'd1);
    check("live_tout", 32'(time_out), 32'd5);
    display_mode = 3'b100; tick();
    check("f5_pulse_end", snd(), 0);
    check("f5_led_hold", 32'(leaderboard_LED), 32'd1);
    check("f_r1_5", 32'(time_out), 32'd5);
    display_mode = 3'b101; tick();
    check("f_r2_empty", 32'(time_out), 0);

    time_in = 6'd6; tick();
    check("f6_sound", snd(), 32'd2);
    check("f6_led", 32'(leaderboard_LED), 32'd2);
    time_in = 6'd9; tick();
    check("f9_sound", snd(), 32'd4);
    display_mode = 3'b110; tick();
    check("f_r3_9", 32'(time_out), 32'd9);

    time_in = 6'd7; tick();
    check("f7_sound", snd(), 32'd4);
    check("f7_led", 32'(leaderboard_LED), 32'd4);
    tick();
    check("f_r3_7", 32'(time_out), 32'd7);
    display_mode = 3'b101; tick();
    check("f_r2_6", 32'(time_out), 32'd6);

    time_in = 6'd12; tick();
    check("f12_sound", snd(), 0);
    check("f12_led", 32'(leaderboard_LED), 0);
    display_mode = 3'b110; tick();
    check("f12_r3_kept", 32'(time_out), 32'd7);
    display_mode = 3'b111; tick();
    check("disp_111", 32'(time_out), 0);

    // Slow mode
    stopwatch_mode = 2'b10; time_in = 6'd9; tick();
    check("s9_sound", snd(), 32'd1);
    check("s9_sof", 32'(slow_or_fast), 32'd2);
    time_in = 6'd5; tick();
    check("s5_sound", snd(), 32'd2);
    time_in = 6'd7; tick();
    check("s7_sound", snd(), 32'd2);
    check("s7_led", 32'(leaderboard_LED), 32'd2);
    display_mode = 3'b100; tick();
    check("s_r1_9", 32'(time_out), 32'd9);
    display_mode = 3'b101; tick();
    check("s_r2_7", 32'(time_out), 32'd7);
    display_mode = 3'b110; tick();
    check("s_r3_5", 32'(time_out), 32'd5);

    // Back to fast: board untouched
    stopwatch_mode = 2'b01; tick();
    check("back_sof", 32'(slow_or_fast), 32'd1);
    check("back_no_sound", snd(), 0);
    display_mode = 3'b100; tick();
    check("back_r1_5", 32'(time_out), 32'd5);
    display_mode = 3'b101; tick();
    check("back_r2_6", 32'(time_out), 32'd6);
    display_mode = 3'b110; tick();
    check("back_r3_7", 32'(time_out), 32'd7);

    // Tie with existing 6 ranks below it
    time_in = 6'd6; tick();
    check("tie_sound", snd(), 32'd4);
    tick();
    check("tie_r3_6", 32'(time_out), 32'd6);

    // Idle: no submissions, slow_or_fast holds
    stopwatch_mode = 2'b00; time_in = 6'd3; tick();
    check("idle_sound_a", snd(), 0);
    check("idle_sof", 32'(slow_or_fast), 32'd1);
    time_in = 6'd1; tick();
    check("idle_sound_b", snd(), 0);
    check("idle_led", 32'(leaderboard_LED), 32'd4);
    display_mode = 3'b100; tick();
    check("idle_r1_5", 32'(time_out), 32'd5);

    // Held time in fast mode submits once
    stopwatch_mode = 2'b01; time_in = 6'd2; tick();
    check("held_first", snd(), 32'd1);
    tick();
    check("held_second", snd(), 0);
    display_mode = 3'b101; tick();
    check("held_r2_5", 32'(time_out), 32'd5);

    // Zero time ignored
    time_in = 6'd0; tick();
    check("zero_sound", snd(), 0);
    check("zero_led", 32'(leaderboard_LED), 32'd1);
    display_mode = 3'b100; tick();
    check("zero_r1_2", 32'(time_out), 32'd2);

    // Reset while a pulse is high
    time_in = 6'd3; tick();
    check("pre_rst_sound", snd(), 32'd2);
    rst = 1'b1; #1;
    check("rst_sound", snd(), 0);
    check("rst_led", 32'(leaderboard_LED), 0);
    check("rst_tout", 32'(time_out), 0);
    check("rst_sof", 32'(slow_or_fast), 32'd1);
    tick();
    rst = 1'b0; stopwatch_mode = 2'b00; display_mode = 3'b100; tick();
    check("post_rst_r1", 32'(time_out), 0);
    display_mode = 3'b101; tick();
    check("post_rst_r2", 32'(time_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leaderboard.md
Name: leaderboard

Overview:
- Holds two top-3 leaderboards for the stopwatch reaction game: one for fast mode (smallest time is best) and one for slow mode (largest time is best).
- Each new time is ranked against the board for the active mode and inserted if it places. A sound strobe fires for the rank achieved, and the rank LEDs update.
- A display selector picks what appears on time_out: the live time or a stored rank.
- Sits between the stopwatch core (time_in, stopwatch_mode) and the display, LED and sound drivers.

Parameters:
- TIME_W, 6, width of time values.
- SOUND_CYCLES, 4, stretched sound-pulse length in cycles; used only when LEADERBOARD_SOUND_STRETCH_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- time_in  in  TIME_W  current or just-finished stopwatch time.
- stopwatch_mode  in  2  2'b01 = fast, 2'b10 = slow, 2'b00 and 2'b11 = idle (no submissions).
- display_mode  in  3  bit2 = 0 selects live time; bit2 = 1 selects a rank from bits[1:0].
- signal_sound_1  out  1  strobe: new time placed at rank 1.
- signal_sound_2  out  1  strobe: new time placed at rank 2.
- signal_sound_3  out  1  strobe: new time placed at rank 3.
- leaderboard_LED  out  3  one-hot rank of the last submission: bit0 = rank 1, bit2 = rank 3; 000 = not placed.
- slow_or_fast  out  2  board currently shown: 2'b01 = fast, 2'b10 = slow.
- time_out  out  TIME_W  selected display value.

Behaviour:
- Reset (async, rst = 1):
  - All 6 entries invalid and zero; prev_time = 0.
  - sound outputs = 0, leaderboard_LED = 000, slow_or_fast = 2'b01, time_out = 0.
- Submission occurs on an edge where all of the following hold:
  - stopwatch_mode is 01 or 10;
  - time_in != prev_time;
  - time_in != 0.
- prev_time is loaded with time_in on every edge.
- Ranking on the active board:
  - The new time T beats a valid entry E if T < E (fast) or T > E (slow).
  - T always beats an invalid entry.
  - Rank r = 1 + number of valid entries that T does not beat. Ties therefore rank below the existing equal entry.
  - If r <= 3: insert T at rank r, shift lower ranks down one place, discard the old rank 3.
  - If r > 3: the board is unchanged.
- Outputs of a submission, registered on the same edge as the board update:
  - signal_sound_r high for exactly one cycle; the other two sound outputs stay 0.
  - leaderboard_LED = one-hot(r), or 000 if not placed. It holds until the next submission.
  - Only one sound output is high in any cycle.
- slow_or_fast is registered from stopwatch_mode when the mode is 01 or 10; it holds its last value in idle modes.
- time_out is registered (1-cycle latency):
  - display_mode[2] = 0: time_in.
  - display_mode 100 / 101 / 110: rank 1 / 2 / 3 of the board indicated by slow_or_fast; 0 if that entry is invalid.
  - display_mode 111: 0.
- Switching mode never clears either board. The inactive board is frozen.
- Reset mid-operation clears everything immediately, including any sound pulse in flight.

Optional Feature:
- Macro: LEADERBOARD_SOUND_STRETCH_EN.
- Defined:
  - Each sound output stays high for SOUND_CYCLES cycles after its triggering edge, so slow audio drivers can latch it.
  - A new submission during a stretch restarts the counter and switches to the new rank's output; the old output drops the same cycle.
- Undefined:
  - Single-cycle strobes, with no counter logic.

Decomposition:
- leaderboard_pkg holds:
  - MODE_FAST = 2'b01, MODE_SLOW = 2'b10;
  - DISP_LIVE, DISP_RANK1 = 3'b100, DISP_RANK2 = 3'b101, DISP_RANK3 = 3'b110;
  - NUM_RANKS = 3.
- One sub-module, leaderboard_rank_table: a 3-entry sorted table with parameter ASCENDING. Inputs are insert strobe and value; outputs are rank (0 = not placed) and the three entries with valid bits. It is instantiated twice, fast (ASCENDING = 1) and slow (ASCENDING = 0).

Test Plan:
- Reset, then fast mode, submit 5 → signal_sound_1 one-cycle pulse, LED = 001; display 100 → time_out = 5 after one cycle; display 101 → 0 (empty).
- Continue in fast mode, submit 6 then 9 → sound_2 then sound_3 pulses; board reads 5, 6, 9. Submit 7 → sound_3 pulse, board reads 5, 6, 7, and 9 is dropped. Submit 12 → no sound, LED = 000.
- Switch to slow mode, submit 9, 5, 7 → pulses sound_1, sound_2, sound_2; slow board reads 9, 7, 5; slow_or_fast = 10. Switch back to fast → fast board is still 5, 6, 7.
- Tie: fast board 5, 6, 7; submit 6 (time_in changed from a different value) → rank 3, board 5, 6, 6; sound_3.
- Idle mode 00 with time_in changing → no board change, no sound, slow_or_fast holds. time_in held constant in fast mode → exactly one submission. time_in = 0 → ignored.
- Assert rst while a sound pulse is active (with LEADERBOARD_SOUND_STRETCH_EN: mid-stretch) → all outputs are 0 immediately; boards are empty afterwards.
